pixel_ctrl: RTL

- Sequencer directly upstream of the 2x2 pixel array. Drives the shared ERASE, EXPOSE, RAMP-enable (convert) and READ strobes.
- During conversion, drives the 8-bit ADC count onto the array DATA buses.
- During readout, captures the four latched pixel codes from those buses and presents them as one 32-bit frame word with a valid pulse.
- All outputs are registered and synchronous to clk.

---
 rtl/pixel_pkg.sv | 19 +
 rtl/pixel_if.sv | 31 +++
 rtl/pixel_adc_counter.sv | 46 ++++
 rtl/pixel_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel array sequencer.
// Holds the sequencer state encoding, the ADC and pixel-bus widths, and the
// width of the phase timer.
package pixel_pkg;

  localparam int ADC_W   = 8;
  localparam int N_PIX   = 4;
  localparam int PIX_W   = ADC_W * N_PIX;
  localparam int TIMER_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_READ    = 3'd4
  } state_e;

endpackage

// File: rtl/pixel_if.sv
// Bus between the sequencer and the pixel array / frame consumer.
// master : the sequencer (drives strobes, ADC count, captured frame)
// slave  : the array side and frame consumer (drives start, pixel bus values)
interface pixel_if;
  import pixel_pkg::*;

  logic             start;
  logic             busy;
  logic             erase;
  logic             expose;
  logic             convert;
  logic             read;
  logic [ADC_W-1:0] cnt_out;
  logic             cnt_oe;
  logic [PIX_W-1:0] pix_data_in;
  logic [PIX_W-1:0] pixel_data;
  logic             frame_valid;

  modport master (
    input  start, pix_data_in,
    output busy, erase, expose, convert, read, cnt_out, cnt_oe,
           pixel_data, frame_valid
  );

  modport slave (
    output start, pix_data_in,
    input  busy, erase, expose, convert, read, cnt_out, cnt_oe,
           pixel_data, frame_valid
  );

endinterface

// File: rtl/pixel_adc_counter.sv
// 8-bit ADC ramp counter.
// clk   : system clock
// reset : synchronous active-high reset
// clr   : synchronous clear (wins over en)
// en    : count up by one
// count : registered count value
// tc    : terminal count, high when count is all ones
module adc_counter
  import pixel_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [ADC_W-1:0] count,
  output logic             tc
);

  logic [ADC_W-1:0] count_q;
  logic [ADC_W-1:0] count_d;

  // Next count: clear has priority over increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {ADC_W{1'b0}};
    end else if (en) begin
      count_d = count_q + {{(ADC_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {ADC_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == {ADC_W{1'b1}});

endmodule

// File: rtl/pixel_ctrl.sv
// Sequencer for the 2x2 pixel array: erase, expose, ramp conversion, readout.
// clk   : system clock, rising edge
// reset : synchronous active-high reset
// bus   : pixel_if.master -- start/pix_data_in in; busy, erase, expose,
//         convert, read, cnt_out, cnt_oe, pixel_data, frame_valid out.
// Every output is a flop loaded from the next state, so it is valid in the
// same cycle the corresponding state is entered.
module pixel_ctrl
  import pixel_pkg::*;
#(
  parameter int C_ERASE  = 5,
  parameter int C_EXPOSE = 255,
  parameter int C_READ   = 2
) (
  input  logic     clk,
  input  logic     reset,
  pixel_if.master  bus
);

  localparam logic [TIMER_W-1:0] T_ERASE   = TIMER_W'(C_ERASE - 1);
  localparam logic [TIMER_W-1:0] T_EXPOSE  = TIMER_W'(C_EXPOSE - 1);
  localparam logic [TIMER_W-1:0] T_CONVERT = TIMER_W'((1 << ADC_W) - 1);
  localparam logic [TIMER_W-1:0] T_READ    = TIMER_W'(C_READ - 1);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               capture_s;

  logic               busy_q, busy_d;
  logic               erase_q, erase_d;
  logic               expose_q, expose_d;
  logic               convert_q, convert_d;
  logic               read_q, read_d;
  logic               cnt_oe_q, cnt_oe_d;
  logic               frame_valid_q, frame_valid_d;
  logic [PIX_W-1:0]   pixel_data_q, pixel_data_d;

  logic [ADC_W-1:0]   cnt_s;
  logic               cnt_tc_s;
  logic               cnt_en_s;
  logic               cnt_clr_s;

  // The ramp only runs in CONVERT; it clears on the terminal cycle so the
  // count is back at zero when READ begins, and stays cleared elsewhere.
  assign cnt_en_s  = (state_q == ST_CONVERT) && !cnt_tc_s;
  assign cnt_clr_s = (state_q != ST_CONVERT) || cnt_tc_s;

  adc_counter u_adc_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr_s),
    .en    (cnt_en_s),
    .count (cnt_s),
    .tc    (cnt_tc_s)
  );

  // State register, phase timer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      timer_q       <= {TIMER_W{1'b0}};
      busy_q        <= 1'b0;
      erase_q       <= 1'b0;
      expose_q      <= 1'b0;
      convert_q     <= 1'b0;
      read_q        <= 1'b0;
      cnt_oe_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      pixel_data_q  <= {PIX_W{1'b0}};
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      busy_q        <= busy_d;
      erase_q       <= erase_d;
      expose_q      <= expose_d;
      convert_q     <= convert_d;
      read_q        <= read_d;
      cnt_oe_q      <= cnt_oe_d;
      frame_valid_q <= frame_valid_d;
      pixel_data_q  <= pixel_data_d;
    end
  end

  // Next-state and timer: the timer is loaded with (duration-1) on entry and
  // the phase ends when it reaches zero. CONVERT ends on the ADC terminal count.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    capture_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ERASE;
          timer_d = T_ERASE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERASE: begin
        if (timer_q == {TIMER_W{1'b0}}) begin
          state_d = ST_EXPOSE;
          timer_d = T_EXPOSE;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_EXPOSE: begin
        if (timer_q == {TIMER_W{1'b0}}) begin
          state_d = ST_CONVERT;
          timer_d = T_CONVERT;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_CONVERT: begin
        if (cnt_tc_s) begin
          state_d = ST_READ;
          timer_d = T_READ;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_READ: begin
        if (timer_q == {TIMER_W{1'b0}}) begin
          state_d   = ST_IDLE;
          timer_d   = {TIMER_W{1'b0}};
          capture_s = 1'b1;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = {TIMER_W{1'b0}};
      end
    endcase
  end

  // Output decode from the next state, so outputs line up with the state.
  always_comb begin
    busy_d        = (state_d != ST_IDLE);
    erase_d       = (state_d == ST_ERASE);
    expose_d      = (state_d == ST_EXPOSE);
    convert_d     = (state_d == ST_CONVERT);
    read_d        = (state_d == ST_READ);
    cnt_oe_d      = (state_d == ST_CONVERT);
    frame_valid_d = capture_s;
    if (capture_s) begin
      pixel_data_d = bus.pix_data_in;
    end else begin
      pixel_data_d = pixel_data_q;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.erase       = erase_q;
  assign bus.expose      = expose_q;
  assign bus.convert     = convert_q;
  assign bus.read        = read_q;
  assign bus.cnt_out     = cnt_s;
  assign bus.cnt_oe      = cnt_oe_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.pixel_data  = pixel_data_q;

endmodule
